// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for instruction fetch and load/store, with registered memory port.
// Define ARB_STARVE_GUARD_EN to cap consecutive data grants while a fetch is waiting.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int PC_W       = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [PC_W-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_d;
  logic       owner_data;
  logic       grant_d, grant_if;
  logic       starve_force;
  logic [3:0] starve_cnt;

`ifdef ARB_STARVE_GUARD_EN
  // Counts data grants that overtook a waiting fetch; any fetch grant clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (grant_if) begin
      starve_cnt <= 4'd0;
    end else if (grant_d && if_req) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  // Constant zero never matches a legal limit, so fetch only wins when d_req is low.
  assign starve_cnt = 4'd0;
`endif

  assign starve_force = (starve_cnt == STARVE_LIM) && if_req;

  always_comb begin
    state_d  = state;
    grant_d  = 1'b0;
    grant_if = 1'b0;
    case (state)
      ACCESS: state_d = RESP;
      default: begin
        if (d_req && !starve_force) begin
          grant_d = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end
        state_d = (grant_d || grant_if) ? ACCESS : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      mem_en     <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state    <= state_d;
      if_gnt   <= grant_if;
      d_gnt    <= grant_d;
      mem_en   <= grant_if | grant_d;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      // Sampling edge: latch the winner onto the memory port
      if (grant_d) begin
        owner_data <= 1'b1;
        mem_rw     <= d_rw;
        mem_addr   <= d_addr;
        mem_wdata  <= d_wdata;
      end else if (grant_if) begin
        owner_data <= 1'b0;
        mem_rw     <= 1'b0;
        mem_addr   <= ADDR_W'(if_addr);
      end
      // ACCESS->RESP edge: capture read data and raise the owner's valid
      if (state == ACCESS) begin
        if (owner_data) begin
          d_valid <= 1'b1;
          if (!mem_rw) begin
            d_rdata <= mem_rdata;
          end
        end else begin
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM; checks run at the falling edge.
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int PC_W   = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [PC_W-1:0]   if_addr;
  logic              if_gnt, if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_rw;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt, d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en, mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic [DATA_W-1:0] ram [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_en && mem_rw) ram[mem_addr] <= mem_wdata;
  end

  mem_arbiter #(.ADDR_W(ADDR_W), .PC_W(PC_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  int d_before, d_between, if_seen, d_total;

  initial begin
    ram[16'h0005] = 32'hDEADBEEF;
    ram[16'h0010] = 32'h11111111;
    ram[16'h1234] = 32'hCAFEF00D;
    ram[16'h0020] = 32'h20202020;
    ram[16'h00FF] = 32'h0F0F0F0F;
    ram[16'h0001] = 32'h00000001;
    ram[16'h0002] = 32'h00000002;
    ram[16'h4000] = 32'h0;

    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_rw = 1'b0; d_addr = '0; d_wdata = '0;
    step(); step(); step();

    // Reset state
    check("rst_if_gnt",   64'(if_gnt),   64'd0);
    check("rst_d_gnt",    64'(d_gnt),    64'd0);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_d_valid",  64'(d_valid),  64'd0);
    check("rst_mem_en",   64'(mem_en),   64'd0);
    check("rst_mem_rw",   64'(mem_rw),   64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata",64'(mem_wdata),64'd0);
    check("rst_if_rdata", 64'(if_rdata), 64'd0);
    check("rst_d_rdata",  64'(d_rdata),  64'd0);

    // Fetch only
    rst = 1'b0; if_req = 1'b1; if_addr = 8'h05;
    step();
    check("f_if_gnt",   64'(if_gnt),   64'd1);
    check("f_mem_en",   64'(mem_en),   64'd1);
    check("f_mem_addr", 64'(mem_addr), 64'h0005);
    check("f_mem_rw",   64'(mem_rw),   64'd0);
    check("f_d_gnt",    64'(d_gnt),    64'd0);
    if_req = 1'b0;
    step();
    check("f_if_valid", 64'(if_valid), 64'd1);
    check("f_if_rdata", 64'(if_rdata), 64'hDEADBEEF);
    check("f_mem_en_2", 64'(mem_en),   64'd0);
    check("f_if_gnt_2", 64'(if_gnt),   64'd0);
    step();
    check("f_if_valid_3", 64'(if_valid), 64'd0);

    // Tie: data first, fetch follows with no idle cycle
    if_req = 1'b1; if_addr = 8'h10;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 16'h1234;
    step();
    check("tie_d_gnt",    64'(d_gnt),    64'd1);
    check("tie_if_gnt",   64'(if_gnt),   64'd0);
    check("tie_mem_addr", 64'(mem_addr), 64'h1234);
    d_req = 1'b0;
    step();
    check("tie_d_valid",  64'(d_valid),  64'd1);
    check("tie_d_rdata",  64'(d_rdata),  64'hCAFEF00D);
    check("tie_if_gnt_2", 64'(if_gnt),   64'd0);
    step();
    check("tie_if_gnt_3", 64'(if_gnt),   64'd1);
    check("tie_f_addr",   64'(mem_addr), 64'h0010);
    check("tie_d_valid_3",64'(d_valid),  64'd0);
    if_req = 1'b0;
    step();
    check("tie_if_valid", 64'(if_valid), 64'd1);
    check("tie_if_rdata", 64'(if_rdata), 64'h11111111);
    step();

    // Write then read
    d_req = 1'b1; d_rw = 1'b1; d_addr = 16'h4000; d_wdata = 32'hA5A5A5A5;
    step();
    check("wr_d_gnt",     64'(d_gnt),     64'd1);
    check("wr_mem_rw",    64'(mem_rw),    64'd1);
    check("wr_mem_en",    64'(mem_en),    64'd1);
    check("wr_mem_wdata", 64'(mem_wdata), 64'hA5A5A5A5);
    check("wr_if_valid",  64'(if_valid),  64'd0);
    d_req = 1'b0;
    step();
    check("wr_d_valid",   64'(d_valid),   64'd1);
    check("wr_mem_rw_2",  64'(mem_rw),    64'd1);
    check("wr_d_rdata_hold", 64'(d_rdata), 64'hCAFEF00D);
    check("wr_if_valid_2",64'(if_valid),  64'd0);
    d_req = 1'b1; d_rw = 1'b0; d_addr = 16'h4000; d_wdata = 32'h0;
    step();
    check("rd_d_gnt",     64'(d_gnt),     64'd1);
    check("rd_mem_rw",    64'(mem_rw),    64'd0);
    check("rd_if_valid",  64'(if_valid),  64'd0);
    d_req = 1'b0;
    step();
    check("rd_d_valid",   64'(d_valid),   64'd1);
    check("rd_d_rdata",   64'(d_rdata),   64'hA5A5A5A5);
    check("rd_if_valid_2",64'(if_valid),  64'd0);
    step();

    // Reset during ACCESS of a read, then fetch with address wrap
    d_req = 1'b1; d_rw = 1'b0; d_addr = 16'h0020;
    step();
    check("rm_d_gnt", 64'(d_gnt), 64'd1);
    rst = 1'b1; d_req = 1'b0;
    step();
    check("rm_d_valid", 64'(d_valid), 64'd0);
    check("rm_mem_en",  64'(mem_en),  64'd0);
    check("rm_d_gnt_2", 64'(d_gnt),   64'd0);
    check("rm_if_gnt",  64'(if_gnt),  64'd0);
    check("rm_d_rdata", 64'(d_rdata), 64'd0);
    rst = 1'b0; if_req = 1'b1; if_addr = 8'hFF;
    step();
    check("wrap_if_gnt",   64'(if_gnt),   64'd1);
    check("wrap_mem_addr", 64'(mem_addr), 64'h00FF);
    check("wrap_d_valid",  64'(d_valid),  64'd0);
    if_req = 1'b0;
    step();
    check("wrap_if_valid", 64'(if_valid), 64'd1);
    check("wrap_if_rdata", 64'(if_rdata), 64'h0F0F0F0F);
    step();

    // Starvation: d_req held high, fetch waiting from the start
    d_req = 1'b1; d_rw = 1'b0; d_addr = 16'h0001;
    if_req = 1'b1; if_addr = 8'h02;
    d_before = 0; d_between = 0; if_seen = 0; d_total = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (d_gnt) begin
        d_total++;
        if (if_seen == 0) d_before++;
        else if (if_seen == 1) d_between++;
      end
      if (if_gnt) if_seen++;
    end
`ifdef ARB_STARVE_GUARD_EN
    check("starve_d_before",  64'(d_before),  64'd4);
    check("starve_d_between", 64'(d_between), 64'd4);
    check("starve_if_gnts",   64'(if_seen),   64'd4);
`else
    check("starve_if_gnts",   64'(if_seen),   64'd0);
    check("starve_d_total",   64'(d_total),   64'd20);
`endif
    d_req = 1'b0; if_req = 1'b0;
    step(); step(); step();
    check("end_mem_en", 64'(mem_en), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
